// File: rtl/rom_dl_streamer.sv
// rtl/rom_dl_streamer.sv - ROM image streamer: host byte fetch, paced dl_wr replay, core reset and checksum
module rom_dl_streamer #(
  parameter int unsigned IMAGE_SIZE = 'h5000,
  parameter logic [24:0] SRC_BASE   = 25'd0,
  parameter int unsigned WR_GAP     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        src_req,
  output logic [24:0] src_addr,
  input  logic        src_ack,
  input  logic [7:0]  src_data,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic        busy,
  output logic        done,
  output logic        core_rst,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  // Index of the final byte; the load ends after this byte's write and gap.
  localparam logic [24:0] LAST_IDX = 25'(IMAGE_SIZE - 1);
  // Gap counter counts down from WR_GAP-1 to 0, one GAP cycle per step.
  localparam logic [3:0]  GAP_LAST = 4'(WR_GAP - 1);
  localparam bit          HAS_GAP  = (WR_GAP != 0);

  state_t      state;
  state_t      state_next;
  logic [24:0] count;
  logic [24:0] count_next;
  logic [3:0]  gap_cnt;
  logic [3:0]  gap_cnt_next;
  logic        launch;
  logic        byte_end;

  // Next-state logic: walk FETCH -> WRITE -> GAP per byte, then advance or finish.
  always_comb begin
    state_next   = state;
    count_next   = count;
    gap_cnt_next = gap_cnt;
    launch       = 1'b0;
    byte_end     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_FETCH;
          count_next = 25'd0;
          launch     = 1'b1;
        end
      end
      S_FETCH: begin
        if (src_ack) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (HAS_GAP) begin
          state_next   = S_GAP;
          gap_cnt_next = GAP_LAST;
        end else begin
          byte_end = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          byte_end = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt - 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (byte_end) begin
      if (count == LAST_IDX) begin
        state_next = S_DONE;
      end else begin
        count_next = count + 25'd1;
        state_next = S_FETCH;
      end
    end
  end

  // State, byte index and gap counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= 25'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // Status and fetch outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_req  <= 1'b0;
      src_addr <= SRC_BASE;
      busy     <= 1'b0;
      done     <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      src_req  <= (state_next == S_FETCH);
      src_addr <= SRC_BASE + count_next;
      busy     <= (state_next == S_FETCH) || (state_next == S_WRITE) || (state_next == S_GAP);
      done     <= (state_next == S_DONE);
      core_rst <= (state_next != S_DONE);
    end
  end

  // Download datapath: capture the acked byte, strobe it once, accumulate the checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_wr    <= 1'b0;
      dl_addr  <= 25'd0;
      dl_data  <= 8'd0;
      checksum <= 8'd0;
    end else begin
      dl_wr <= (state == S_FETCH) && src_ack;
      if ((state == S_FETCH) && src_ack) begin
        dl_data <= src_data;
        dl_addr <= count;
      end
      if (launch) begin
        checksum <= 8'd0;
      end else if (state == S_WRITE) begin
        checksum <= checksum + dl_data;
      end
    end
  end

endmodule

// File: doc/rom_dl_streamer.md
# rom_dl_streamer

Transmit end of the ROM download port that the arcade top level receives on `dl_addr`/`dl_data`/`dl_wr`. On `start` it fetches a contiguous image byte by byte from a host-side byte source via a req/ack handshake. It then replays each byte as a single-cycle `dl_wr` pulse with a guaranteed idle gap between writes. It holds the game core in reset while loading and reports completion and an 8-bit additive checksum.

## Interface
Parameters:
- `IMAGE_SIZE`, default 'h5000: bytes to stream; program ROM occupies 'h0000–'h3FFF, vector ROM 'h4000–'h4FFF. Legal range 1..2^24.
- `SRC_BASE`, default 0: source address of image byte 0.
- `WR_GAP`, default 3: idle cycles after each `dl_wr` pulse. Legal range 0..15.

Ports:
- `clk`  in  1  system clock. Single clock domain; same clock as the top level.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load. Honoured only in IDLE or DONE.
- `src_req`  out  1  byte fetch request. Held high until acknowledged.
- `src_addr`  out  25  source address, equal to `SRC_BASE + count`. Stable while `src_req` is high.
- `src_ack`  in  1  one-cycle acknowledge. `src_data` is valid in the same cycle.
- `src_data`  in  8  fetched byte.
- `dl_addr`  out  25  download address, equal to `count`.
- `dl_data`  out  8  download byte.
- `dl_wr`  out  1  one-cycle write strobe.
- `busy`  out  1  high in FETCH, WRITE and GAP.
- `done`  out  1  sticky; high in DONE.
- `core_rst`  out  1  high whenever not in DONE. Drives the core reset input.
- `checksum`  out  8  mod-256 sum of all bytes written since the last `start`.

## Operation
States: IDLE, FETCH, WRITE, GAP, DONE.

Transitions:
- IDLE --start--> FETCH. On entry: `count`=0, `checksum`=0.
- FETCH --src_ack--> WRITE. `src_data` is captured into the `dl_data` register on the ack cycle.
- WRITE: `dl_wr`=1 for exactly one cycle, with `dl_addr`=`count`. `checksum += dl_data` on this cycle.
- After WRITE:
  - If `WR_GAP` > 0: go to GAP and count `WR_GAP` cycles.
  - If `WR_GAP` = 0: skip GAP.
- End of GAP (or WRITE when `WR_GAP`=0):
  - If `count == IMAGE_SIZE-1`: go to DONE.
  - Otherwise: `count++` and go to FETCH.
- DONE --start--> FETCH, with a restart that clears `count`, `checksum` and `done`.

Other rules:
- `src_ack` is ignored in every state except FETCH.
- `start` is ignored in FETCH, WRITE and GAP.
- `count` is 25 bits. `src_addr` is computed as a 25-bit add and wraps modulo 2^25.
- `dl_addr` and `dl_data` hold their last values outside WRITE. The receiver may only sample them while `dl_wr` is high.

Reset values (on the cycle after `rst` is asserted):
- state = IDLE
- `src_req`=0, `dl_wr`=0, `busy`=0, `done`=0
- `core_rst`=1
- `dl_addr`=0, `dl_data`=0, `src_addr`=`SRC_BASE`, `checksum`=0

Reset mid-load: the load is abandoned with no further `dl_wr`. A pending ack arriving after reset is ignored.

## Timing
- Latencies:
  - `start` in cycle 0 → `src_req`=1 in cycle 1.
  - `src_ack` in cycle n → `dl_wr`=1 in cycle n+1.
- `src_req` is a registered output. It drops on the cycle after the ack (the WRITE cycle).
- Minimum byte period is `2+WR_GAP` cycles, when ack arrives in the first FETCH cycle. Default: 5 cycles per byte, so 'h5000 bytes take 102400 cycles plus ack latency.
- Consecutive `dl_wr` pulses are never closer than `WR_GAP+1` cycles apart. With `WR_GAP`=0 they are still separated by at least one FETCH cycle.
- `done` rises and `core_rst` falls in the cycle after the last GAP (or WRITE) cycle.
- `checksum` is final when `done`=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- IMAGE_SIZE=4, WR_GAP=3, ack with zero wait, source bytes 'h11,'h22,'h33,'h44:
  - `dl_wr` pulses at dl_addr 0..3 carry those bytes, with pulses exactly 5 cycles apart.
  - `checksum`='hAA, then `done`=1 and `core_rst`=0.
- Ack delayed 7 cycles on byte 2:
  - `src_req` is held with `src_addr` stable for all 7 cycles.
  - Exactly one `dl_wr` for byte 2, issued the cycle after the ack.
  - Spurious `src_ack` pulses during GAP create no writes.
- Default parameters, source byte = low 8 bits of its address:
  - Sequence crosses the 'h3FFF→'h4000 boundary with no skipped or duplicated address.
  - Last write is at dl_addr='h4FFF with data 'hFF.
  - 'h5000 `dl_wr` pulses in total, `checksum`='h00.
- `rst` asserted during the GAP after byte 10:
  - No further `dl_wr`; all outputs return to their reset values.
  - A fresh `start` reloads from dl_addr 0 with `checksum` reset.
- `start` pulsed mid-load is ignored (count is unaffected). `start` pulsed in DONE restarts the load: `done`=0 and `core_rst`=1 in the next cycle.
- WR_GAP=0, SRC_BASE='h1FFFFFF, IMAGE_SIZE=2:
  - `src_addr` sequence is 'h1FFFFFF then 'h0000000 (wrap).
  - `dl_wr` pulses are 2 cycles apart.
